tcm_sram_port_ctrl: RTL and testbench



---
 rtl/tcm_sram_pkg.sv | 14 +
 rtl/tcm_resp_fifo.sv | 35 +++
 rtl/tcm_sram_port_ctrl.sv | 117 +++++++++++
 tb/tb_tcm_sram_port_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/tcm_sram_pkg.sv
// tcm_sram_pkg: shared types, constants and window helper for the TCM SRAM port controller
package tcm_sram_pkg;
   localparam int OFFS_W = 3;
   localparam int RESP_DW = 64;
   typedef enum logic {CLEAR, RUN} state_e;
   typedef struct packed {
      logic [RESP_DW-1:0] data;
      logic               err;
      logic               write;
   } resp_t;
   function automatic logic [32:0] win_bytes(input int aw);
      return 33'd1 << (aw + OFFS_W);
   endfunction
endpackage

// File: rtl/tcm_resp_fifo.sv
// tcm_resp_fifo: first-word fall-through FIFO of response records
module tcm_resp_fifo
   import tcm_sram_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  push,
   input  resp_t din,
   input  logic  pop,
   output resp_t dout,
   output logic  vld
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   resp_t         mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   assign vld  = cnt != '0;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         wr_ptr <= !push ? wr_ptr : wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + PW'(1);
         rd_ptr <= !pop ? rd_ptr : rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + PW'(1);
         cnt    <= push && !pop ? cnt + CW'(1) : !push && pop ? cnt - CW'(1) : cnt;
      end
   end
   always_ff @(posedge clk_i)
      if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/tcm_sram_port_ctrl.sv
// tcm_sram_port_ctrl: valid/ready front end for one port of the TCM SRAM macro, with zero-fill after reset
module tcm_sram_port_ctrl
   import tcm_sram_pkg::*;
#(
   parameter int          DATA_WIDTH     = 64,
   parameter int          NUM_WMASKS     = 8,
   parameter int          ADDR_WIDTH     = 5,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          RESP_DEPTH     = 4,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [31:0]           req_addr_i,
   input  logic                  req_we_i,
   input  logic [NUM_WMASKS-1:0] req_wstrb_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   input  logic                  resp_ready_i,
   output logic [DATA_WIDTH-1:0] resp_data_o,
   output logic                  resp_err_o,
   output logic                  resp_write_o,
   output logic                  init_done_o,
   output logic                  sram_csb_o,
   output logic                  sram_web_o,
   output logic [NUM_WMASKS-1:0] sram_wmask_o,
   output logic [ADDR_WIDTH-1:0] sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_din_o,
   input  logic [DATA_WIDTH-1:0] sram_dout_i
);
   localparam int PW = $clog2(RESP_DEPTH + 1);
   localparam logic [32:0] WIN = win_bytes(ADDR_WIDTH);
   state_e                state, state_nxt;
   logic [ADDR_WIDTH-1:0] clr_cnt, addr_nxt;
   logic [PW-1:0]         pend;
   logic [31:0]           offs;
   logic                  hit, acc, pop, fifo_vld;
   logic                  s1_vld, s1_err, s1_wr, s1_rd, s2_vld, s2_err, s2_wr, s2_rd;
   logic                  csb_nxt, web_nxt;
   logic [NUM_WMASKS-1:0] wmask_nxt;
   logic [DATA_WIDTH-1:0] din_nxt;
   resp_t                 push_rec, pop_rec;
   assign offs        = req_addr_i - BASE_ADDR;
   assign hit         = {1'b0, offs} < WIN;
   assign req_ready_o = !rst_i && state == RUN && pend < PW'(RESP_DEPTH);
   assign acc         = req_valid_i && req_ready_o;
   assign pop         = resp_valid_o && resp_ready_i;
   always_comb begin
      state_nxt = state;
      csb_nxt   = 1'b1;
      web_nxt   = 1'b1;
      wmask_nxt = '0;
      addr_nxt  = sram_addr_o;
      din_nxt   = sram_din_o;
      if (state == CLEAR) begin
         csb_nxt   = 1'b0;
         web_nxt   = 1'b0;
         wmask_nxt = '1;
         addr_nxt  = clr_cnt;
         din_nxt   = '0;
         state_nxt = clr_cnt == '1 ? RUN : CLEAR;
      end else if (acc && hit) begin
         csb_nxt   = 1'b0;
         web_nxt   = !req_we_i;
         wmask_nxt = req_we_i ? req_wstrb_i : '0;
         addr_nxt  = offs[ADDR_WIDTH+OFFS_W-1:OFFS_W];
         din_nxt   = req_we_i ? req_wdata_i : sram_din_o;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= CLEAR_ON_RESET ? CLEAR : RUN;
         clr_cnt      <= '0;
         pend         <= '0;
         {s1_vld, s1_err, s1_wr, s1_rd} <= '0;
         {s2_vld, s2_err, s2_wr, s2_rd} <= '0;
         init_done_o  <= 1'b0;
         sram_csb_o   <= 1'b1;
         sram_web_o   <= 1'b1;
         sram_wmask_o <= '0;
         sram_addr_o  <= '0;
         sram_din_o   <= '0;
      end else begin
         state        <= state_nxt;
         clr_cnt      <= state == CLEAR ? clr_cnt + ADDR_WIDTH'(1) : '0;
         pend         <= acc && !pop ? pend + PW'(1) : !acc && pop ? pend - PW'(1) : pend;
         s1_vld       <= acc;
         s1_err       <= acc && !hit;
         s1_wr        <= acc && req_we_i;
         s1_rd        <= acc && hit && !req_we_i;
         {s2_vld, s2_err, s2_wr, s2_rd} <= {s1_vld, s1_err, s1_wr, s1_rd};
         init_done_o  <= state == RUN;
         sram_csb_o   <= csb_nxt;
         sram_web_o   <= web_nxt;
         sram_wmask_o <= wmask_nxt;
         sram_addr_o  <= addr_nxt;
         sram_din_o   <= din_nxt;
      end
   end
   // macro read data is valid during the cycle after it sampled the pins
   assign push_rec = '{data: s2_rd ? RESP_DW'(sram_dout_i) : '0, err: s2_err, write: s2_wr};
   tcm_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (s2_vld),
      .din   (push_rec),
      .pop   (pop),
      .dout  (pop_rec),
      .vld   (fifo_vld)
   );
   assign resp_valid_o = fifo_vld;
   assign resp_data_o  = fifo_vld ? pop_rec.data[DATA_WIDTH-1:0] : '0;
   assign resp_err_o   = fifo_vld && pop_rec.err;
   assign resp_write_o = fifo_vld && pop_rec.write;
endmodule

// File: tb/tb_tcm_sram_port_ctrl.sv
// tb_tcm_sram_port_ctrl: directed bench pairing the controller with a single-port SRAM macro model
module tb_tcm_sram_port_ctrl;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        req_valid_i = 1'b0, req_we_i = 1'b0, resp_ready_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [7:0]  req_wstrb_i = '0;
   logic [63:0] req_wdata_i = '0;
   logic        req_ready_o, resp_valid_o, resp_err_o, resp_write_o, init_done_o;
   logic        sram_csb_o, sram_web_o;
   logic [63:0] resp_data_o, sram_din_o, sram_dout_i;
   logic [7:0]  sram_wmask_o;
   logic [4:0]  sram_addr_o;
   logic [63:0] mem [32];
   int          tests = 0, fails = 0;
   always #5 clk_i = ~clk_i;
   tcm_sram_port_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .req_we_i(req_we_i), .req_wstrb_i(req_wstrb_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
      .resp_err_o(resp_err_o), .resp_write_o(resp_write_o), .init_done_o(init_done_o),
      .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o), .sram_wmask_o(sram_wmask_o),
      .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i)
   );
   function automatic logic [63:0] bmask(input logic [7:0] w);
      for (int b = 0; b < 8; b++) bmask[b*8+:8] = {8{w[b]}};
   endfunction
   function automatic logic [63:0] pat(input int i);
      return {32'hC0DE_0000 | 32'(i), 32'h1234_5600 | 32'(i)};
   endfunction
   // macro port 0; port 1 of the macro is left idle
   always @(posedge clk_i)
      if (!sram_csb_o) begin
         if (!sram_web_o) mem[sram_addr_o] <= (mem[sram_addr_o] & ~bmask(sram_wmask_o)) | (sram_din_o & bmask(sram_wmask_o));
         else sram_dout_i <= mem[sram_addr_o];
      end
   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step;
      @(posedge clk_i);
      #1;
   endtask
   task automatic reset_chk(input string tag);
      chk(tag, {req_ready_o, resp_valid_o, resp_data_o, resp_err_o, resp_write_o, init_done_o,
                sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o},
               {1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 5'h00, 64'h0});
   endtask
   task automatic clear_seq;
      for (int k = 0; k < 32; k++) begin
         step();
         chk("clear_pins", {sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o, resp_valid_o, init_done_o},
                           {1'b0, 1'b0, 8'hFF, 5'(k), 64'h0, 1'b0, 1'b0});
      end
      chk("clear_ready", {req_ready_o, init_done_o}, {1'b1, 1'b0});
      step();
      chk("init_done", {init_done_o, sram_csb_o, sram_web_o, sram_wmask_o}, {1'b1, 1'b1, 1'b1, 8'h00});
   endtask
   task automatic xact(input string tag, input logic we, input logic [31:0] a, input logic [7:0] s,
                       input logic [63:0] d, input logic [63:0] exp_d, input logic exp_err);
      logic hit;
      hit = a < 32'h100;
      req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wstrb_i = s; req_wdata_i = d;
      resp_ready_i = 1'b1;
      chk({tag, "_ready"}, req_ready_o, 1);
      step();
      req_valid_i = 1'b0;
      chk({tag, "_pins"}, {sram_csb_o, sram_web_o, sram_wmask_o},
                          hit ? {1'b0, !we, we ? s : 8'h00} : {1'b1, 1'b1, 8'h00});
      if (hit) chk({tag, "_addr"}, {sram_addr_o, we ? sram_din_o : 64'h0}, {a[7:3], we ? d : 64'h0});
      step();
      chk({tag, "_lat1"}, {resp_valid_o, sram_csb_o}, {1'b0, 1'b1});
      step();
      chk({tag, "_resp"}, {resp_valid_o, resp_data_o, resp_err_o, resp_write_o}, {1'b1, exp_d, exp_err, we});
      step();
      chk({tag, "_pop"}, resp_valid_o, 0);
   endtask
   initial begin
      int          issued, popped, pend, dropped;
      logic        acc, pop;
      logic [63:0] e_data [10];
      logic        e_err [10];
      repeat (3) step();
      reset_chk("reset_vals");
      rst_i = 1'b0;
      clear_seq();
      xact("rd7", 1'b0, 32'h38, 8'h00, 64'h0, 64'h0, 1'b0);
      xact("wr3", 1'b1, 32'h18, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
      xact("rd3", 1'b0, 32'h18, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
      xact("wr3m", 1'b1, 32'h18, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
      xact("rd3m", 1'b0, 32'h1C, 8'h00, 64'h0, 64'h0123_4567_FFFF_FFFF, 1'b0);
      xact("wr0s", 1'b1, 32'h18, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 64'h0, 1'b0);
      xact("rd3z", 1'b0, 32'h18, 8'h00, 64'h0, 64'h0123_4567_FFFF_FFFF, 1'b0);
      xact("miss", 1'b0, 32'h100, 8'h00, 64'h0, 64'h0, 1'b1);
      for (int i = 0; i < 10; i++) xact("fill", 1'b1, 32'(i * 8), 8'hFF, pat(i), 64'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         e_data[i] = i == 5 ? 64'h0 : pat(i);
         e_err[i]  = i == 5;
      end
      issued = 0; popped = 0; pend = 0; dropped = 0;
      for (int c = 0; c < 80 && popped < 10; c++) begin
         resp_ready_i = c[0];
         req_valid_i  = issued < 10;
         req_we_i     = 1'b0;
         req_addr_i   = issued == 5 ? 32'h100 : 32'(issued * 8);
         chk("burst_ready", req_ready_o, pend < 4);
         if (req_ready_o === 1'b0) dropped = 1;
         acc = req_valid_i && req_ready_o;
         pop = resp_valid_o && resp_ready_i;
         if (pop) begin
            chk("burst_resp", {resp_err_o, resp_write_o, resp_data_o}, {e_err[popped], 1'b0, e_data[popped]});
            popped++;
         end
         if (acc) issued++;
         pend = pend + int'(acc) - int'(pop);
         step();
      end
      req_valid_i = 1'b0;
      resp_ready_i = 1'b1;
      chk("burst_count", popped, 10);
      chk("burst_drop", dropped, 1);
      repeat (3) step();
      chk("burst_extra", resp_valid_o, 0);
      resp_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'(i * 8);
         chk("flush_acc", req_ready_o, 1);
         step();
      end
      req_valid_i = 1'b0;
      rst_i = 1'b1;
      step();
      step();
      reset_chk("flush_reset");
      rst_i = 1'b0;
      resp_ready_i = 1'b1;
      clear_seq();
      repeat (4) step();
      chk("flush_noresp", resp_valid_o, 0);
      xact("rd1clr", 1'b0, 32'h08, 8'h00, 64'h0, 64'h0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
